// File: rtl/ram_proto_pkg.sv
// Protocol definitions shared by the read_write_ram initiator and ram_responder.
package ram_proto_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_ADDR_WIDTH = 4;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = 4;

endpackage

// File: rtl/ram_array.sv
// Single-port synchronous storage with write enable and registered read; no reset.
module ram_array #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder: one outstanding request, fixed latency, response held until taken.
module ram_responder
  import ram_proto_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WIDTH-1:0]      resp_rdata,
  output logic                  resp_err,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             rd_ok;
  logic             in_range;
  logic             accept;
  logic [WIDTH-1:0] mem_q;

  // Full-width compare so addresses past DEPTH never alias onto real words.
  assign in_range  = {1'b0, req_addr} < DEPTH_W;
  assign req_ready = rst && (state == IDLE);
  assign accept    = req_valid && req_ready;

  ram_array #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (accept && req_we && in_range),
    .re    (accept && !req_we && in_range),
    .addr  (req_addr),
    .wdata (req_wdata),
    .rdata (mem_q)
  );

  // Array output only updates on read acceptance, so it is stable throughout RESP.
  assign resp_rdata = rd_ok ? mem_q : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rd_ok      <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            rd_ok    <= !req_we && in_range;
            resp_err <= !in_range;
            cnt      <= CNT_W'(LATENCY - 1);
            busy     <= 1'b1;
            if (LATENCY == 1) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            rd_ok      <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
